branch_predict_resolve: RTL
===========================

Name: branch_predict_resolve

Overview:
- Parametrised successor to the MEM-stage branch resolution logic.
- Adds a branch history table (BHT) of saturating counters, read in IF to produce a taken prediction and trained in MEM when branches resolve.
- MEM-side outputs keep the existing resolution semantics (trigger/decision/mispredict) and add an explicit not-taken recovery signal.
- After reset, a sweep FSM initialises the table so that it maps onto RAM-style storage.

Parameters:
- ADDR_WIDTH, 32, PC width.
- IDX_BITS, 6, table index width; table holds 2^IDX_BITS entries.
- CTR_WIDTH, 2, saturating counter width (>=1).

Ports:
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset
- if_pc  input  ADDR_WIDTH  fetch PC for lookup
- predict_taken  output  1  IF prediction; counter MSB of the indexed entry
- ready  output  1  high once table initialisation completes
- mem_valid  input  1  MEM stage holds a valid instruction
- mem_pc  input  ADDR_WIDTH  PC of the MEM-stage instruction
- mem_branch  input  1  instruction is a conditional branch
- mem_branch_enable  input  1  branch condition evaluated true
- mem_jump  input  1  instruction is an unconditional jump
- mem_predicted  input  1  prediction carried down the pipeline for this instruction
- branch_jump_trigger  output  1  redirect fetch to the branch/jump target
- decision  output  1  actual branch outcome
- mispredict  output  1  predicted taken, actually not taken; redirect to PC+4
- mispredict_any  output  1  either mispredict direction or jump trigger; flush request

Behaviour:
- Index: idx = pc[IDX_BITS+1:2], applied to both if_pc and mem_pc.
- Counter semantics:
  - Unsigned, CTR_WIDTH bits.
  - Taken prediction = MSB.
  - Initial value WNT = 2^(CTR_WIDTH-1)-1.
- FSM states: INIT, RUN.
- Reset:
  - rst_n=0 at a clk edge: state<=INIT, init_ptr<=0.
  - All outputs are low while rst_n=0 and throughout INIT.
- INIT:
  - Each cycle writes WNT to entry init_ptr, then init_ptr++.
  - Leaves INIT after writing entry 2^IDX_BITS-1: exactly 2^IDX_BITS cycles after reset release.
  - ready=1 from the first RUN cycle.
  - Training is ignored during INIT.
  - Reset asserted mid-INIT restarts the sweep at 0.
- RUN, IF lookup:
  - predict_taken is combinational from the current table contents.
  - Read-before-write: a same-cycle update to the same index is not visible until the next cycle.
- RUN, MEM resolution (combinational, qualified by mem_valid; all zero when mem_valid=0 or in INIT):
  - decision = mem_branch & mem_branch_enable
  - branch_jump_trigger = (~mem_predicted & decision) | mem_jump
  - mispredict = mem_predicted & ~decision
  - mispredict_any = branch_jump_trigger | mispredict
- Training:
  - Happens on a clk edge in RUN when mem_valid & mem_branch.
  - Counter at mem_pc index increments if decision=1, saturating at 2^CTR_WIDTH-1.
  - Otherwise decrements, saturating at 0.
  - Jumps and non-branches never train.
- The table is not cleared by anything other than reset.

Optional Feature:
- Macro BRANCH_PREDICT_STATS_EN.
- When defined, adds outputs stat_branches[31:0] and stat_mispredicts[31:0].
  - Both cleared to 0 on reset.
  - In RUN, stat_branches increments on each mem_valid & mem_branch edge.
  - stat_mispredicts increments when, in addition, mem_predicted != decision.
  - Both wrap modulo 2^32.
  - Read-only, registered, 1-cycle latency.
- When undefined, these ports and counters do not exist and the rest of the behaviour is identical.

Test Plan:
- Reset then release with IDX_BITS=6 -> ready=0 for 64 cycles and 1 on cycle 65; predict_taken=0 for every if_pc.
- Branch at pc 0x40 resolved taken twice (mem_predicted=0) -> counter 1->2->3:
  - branch_jump_trigger=1 on both cycles.
  - predict_taken for if_pc 0x40 becomes 1 after the first update.
  - A third taken resolution leaves the counter saturated at 3.
- Pc 0x40 with counter at 3, predicted=1, resolved not taken -> mispredict=1, branch_jump_trigger=0, counter becomes 2, predict_taken stays 1.
- mem_jump=1 with mem_branch=0 -> branch_jump_trigger=1, decision=0, no table change; same stimulus with mem_valid=0 -> all outputs 0.
- Same-cycle update at 0x80 while if_pc=0x80 (counter 1, taken) -> predict_taken=0 that cycle and 1 the next. Aliasing check: 0x80 and 0x180 share index 32 and see the same counter.
- Reset asserted at INIT cycle 20, and a training request issued during INIT -> sweep restarts, ready rises 64 cycles after release, and the training request has no effect. With BRANCH_PREDICT_STATS_EN: 10 branches including 3 mispredicts -> stat_branches=10, stat_mispredicts=3.

Source files
------------

// File: rtl/branch_predict_resolve.sv
// Branch history table with MEM-stage branch/jump resolution.
// Optional macro BRANCH_PREDICT_STATS_EN adds branch and mispredict counters.
module branch_predict_resolve #(
  parameter int ADDR_WIDTH = 32,
  parameter int IDX_BITS   = 6,
  parameter int CTR_WIDTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] if_pc,
  output logic                  predict_taken,
  output logic                  ready,
  input  logic                  mem_valid,
  input  logic [ADDR_WIDTH-1:0] mem_pc,
  input  logic                  mem_branch,
  input  logic                  mem_branch_enable,
  input  logic                  mem_jump,
  input  logic                  mem_predicted,
  output logic                  branch_jump_trigger,
  output logic                  decision,
  output logic                  mispredict,
  output logic                  mispredict_any
`ifdef BRANCH_PREDICT_STATS_EN
  ,
  output logic [31:0]           stat_branches,
  output logic [31:0]           stat_mispredicts
`endif
);

  localparam int DEPTH = 2 ** IDX_BITS;
  localparam logic [CTR_WIDTH-1:0] WNT =
    CTR_WIDTH'((1 << (CTR_WIDTH - 1)) - 1);
  localparam logic [CTR_WIDTH-1:0] SAT = '1;

  typedef enum logic {INIT, RUN} state_t;

  state_t                state;
  state_t                state_nx;
  logic [IDX_BITS-1:0]   init_ptr;
  logic [IDX_BITS-1:0]   ptr_nx;
  logic [CTR_WIDTH-1:0]  tbl [DEPTH];

  logic [IDX_BITS-1:0]   if_idx;
  logic [IDX_BITS-1:0]   mem_idx;
  logic                  run;
  logic                  dec_raw;
  logic                  train;
  logic [CTR_WIDTH-1:0]  ctr_cur;
  logic [CTR_WIDTH-1:0]  ctr_nx;
  logic                  wr_en;
  logic [IDX_BITS-1:0]   wr_idx;
  logic [CTR_WIDTH-1:0]  wr_data;
  logic                  unused_pc;

  assign if_idx  = if_pc[IDX_BITS+1:2];
  assign mem_idx = mem_pc[IDX_BITS+1:2];
  assign unused_pc = ^{if_pc[ADDR_WIDTH-1:IDX_BITS+2], if_pc[1:0],
                       mem_pc[ADDR_WIDTH-1:IDX_BITS+2], mem_pc[1:0]};

  // Outputs are forced low while reset is held, not just after the edge.
  assign run     = (state == RUN) && rst_n;
  assign dec_raw = mem_branch & mem_branch_enable;
  assign train   = (state == RUN) && mem_valid && mem_branch;

  assign ready         = run;
  assign predict_taken = run & tbl[if_idx][CTR_WIDTH-1];

  // MEM-stage resolution, qualified by a valid instruction in RUN.
  always_comb begin
    decision            = 1'b0;
    branch_jump_trigger = 1'b0;
    mispredict          = 1'b0;
    mispredict_any      = 1'b0;
    if (run && mem_valid) begin
      decision            = dec_raw;
      branch_jump_trigger = (~mem_predicted & dec_raw) | mem_jump;
      mispredict          = mem_predicted & ~dec_raw;
      mispredict_any      = branch_jump_trigger | mispredict;
    end
  end

  // Saturating counter update for the resolving branch.
  always_comb begin
    ctr_cur = tbl[mem_idx];
    ctr_nx  = ctr_cur;
    if (dec_raw) begin
      if (ctr_cur != SAT) ctr_nx = ctr_cur + 1'b1;
    end else begin
      if (ctr_cur != '0) ctr_nx = ctr_cur - 1'b1;
    end
  end

  // Single write port: init sweep in INIT, training in RUN.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = mem_idx;
    wr_data = ctr_nx;
    if (rst_n) begin
      if (state == INIT) begin
        wr_en   = 1'b1;
        wr_idx  = init_ptr;
        wr_data = WNT;
      end else if (train) begin
        wr_en = 1'b1;
      end
    end
  end

  // Table storage has no reset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (wr_en) tbl[wr_idx] <= wr_data;
  end

  // Sweep FSM next state.
  always_comb begin
    state_nx = state;
    ptr_nx   = init_ptr;
    unique case (state)
      INIT: begin
        ptr_nx = init_ptr + 1'b1;
        if (init_ptr == {IDX_BITS{1'b1}}) state_nx = RUN;
      end
      RUN: ;
      default: state_nx = INIT;
    endcase
  end

  // Sweep FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= INIT;
      init_ptr <= '0;
    end else begin
      state    <= state_nx;
      init_ptr <= ptr_nx;
    end
  end

`ifdef BRANCH_PREDICT_STATS_EN
  // Free-running branch and mispredict counters, wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else if (train) begin
      stat_branches <= stat_branches + 32'd1;
      if (mem_predicted != dec_raw)
        stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule
